// File: rtl/addr_latch_bank.sv
// -----------------------------------------------------------------------------
// addr_latch_bank
//
// Bank of N individually addressable control bits written through a
// mode/address/data command port. Each command updates the selected bit:
// LATCH stores d, DEMUX clears every bit except the selected one, TOGGLE
// inverts it, and PULSE sets it high for PULSE_LEN cycles.
//
// Optional feature: define ADDR_LATCH_PULSE_EN to build the per-bit pulse
// timers. Without it no timers exist and PULSE behaves exactly like LATCH.
//
// Parameters:
//   N          number of output bits (2..64)
//   PULSE_LEN  cycles a pulse-mode bit stays high (>= 1)
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   en    in   command strobe
//   clr   in   synchronous clear of all bits and timers (beats en)
//   mode  in   2-bit command: 00 LATCH, 01 DEMUX, 10 PULSE, 11 TOGGLE
//   addr  in   bit select, AW bits wide
//   d     in   write data
//   q     out  N latched control bits (registered)
//   err   out  one-cycle flag after a write to an address >= N
// -----------------------------------------------------------------------------
module addr_latch_bank #(
  parameter  int N         = 8,
  parameter  int PULSE_LEN = 4,
  localparam int AW        = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] addr,
  input  logic          d,
  output logic [N-1:0]  q,
  output logic          err
);

  typedef enum logic [1:0] {
    MODE_LATCH  = 2'b00,
    MODE_DEMUX  = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  if (N < 2 || N > 64 || PULSE_LEN < 1) begin : g_param_check
    $error("addr_latch_bank: N must be 2..64 and PULSE_LEN >= 1");
  end

  mode_e        cmd;
  logic [N-1:0] sel;
  logic         in_range;
  logic [N-1:0] q_q, q_d;
  logic         err_q, err_d;

  assign cmd = mode_e'(mode);

  // One-hot decode of addr. An address with no matching bit is out of range,
  // which can only happen when N is not a power of two.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      sel[i] = (addr == AW'(i));
    end
  end

  assign in_range = |sel;

`ifdef ADDR_LATCH_PULSE_EN
  localparam int            TW         = $clog2(PULSE_LEN + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(PULSE_LEN);

  logic [TW-1:0] timer_q [N];
  logic [TW-1:0] timer_d [N];
  logic [N-1:0]  expire;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      expire[i] = (timer_q[i] == TW'(1));
    end
  end
`endif

  // Layered next-state: timer expiry first, then the command overrides the
  // selected bit(s), then clr overrides everything. Later assignments win,
  // which gives the required priority clr > command > expiry.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    q_d   = q_q;
    err_d = 1'b0;
`ifdef ADDR_LATCH_PULSE_EN
    for (int i = 0; i < N; i++) begin
      timer_d[i] = timer_q[i];
      if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - TW'(1);
      end
    end
    q_d = q_q & ~expire;
`endif

    if (clr) begin
      q_d = '0;
`ifdef ADDR_LATCH_PULSE_EN
      for (int i = 0; i < N; i++) begin
        timer_d[i] = '0;
      end
`endif
    end else if (en) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else begin
        case (cmd)
          MODE_DEMUX:  q_d = sel & {N{d}};
          MODE_TOGGLE: q_d = (q_d & ~sel) | (~q_q & sel);
          default:     q_d = (q_d & ~sel) | (sel & {N{d}});
        endcase
`ifdef ADDR_LATCH_PULSE_EN
        // Any command cancels the timer of the bit it touches (DEMUX touches
        // all of them); a PULSE with d=1 then reloads to the full length.
        for (int i = 0; i < N; i++) begin
          if (cmd == MODE_DEMUX || sel[i]) begin
            timer_d[i] = '0;
          end
          if (cmd == MODE_PULSE && sel[i] && d) begin
            timer_d[i] = TIMER_LOAD;
          end
        end
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

`ifdef ADDR_LATCH_PULSE_EN
  // NOTE: the timer array is reset even though it is array-shaped; a stale
  // count surviving reset would clear a bit some cycles after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end
`endif

  assign q   = q_q;
  assign err = err_q;

endmodule

// File: tb/tb_addr_latch_bank.sv
// -----------------------------------------------------------------------------
// tb_addr_latch_bank
//
// Directed bench for addr_latch_bank. Two instances share all inputs: an
// N=8 bank for the main function and an N=6 bank for out-of-range writes.
// Pulse expectations depend on whether ADDR_LATCH_PULSE_EN is defined.
// -----------------------------------------------------------------------------
module tb_addr_latch_bank;

  localparam logic [1:0] M_LATCH  = 2'b00;
  localparam logic [1:0] M_DEMUX  = 2'b01;
  localparam logic [1:0] M_PULSE  = 2'b10;
  localparam logic [1:0] M_TOGGLE = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] addr = 3'd0;
  logic       d = 1'b0;
  logic [7:0] q8;
  logic       err8;
  logic [5:0] q6;
  logic       err6;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  addr_latch_bank #(.N(8), .PULSE_LEN(4)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .addr(addr), .d(d), .q(q8), .err(err8)
  );

  addr_latch_bank #(.N(6), .PULSE_LEN(4)) u_dut6 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .addr(addr), .d(d), .q(q6), .err(err6)
  );

  // One command on one rising edge; returns 1 time unit after that edge.
  task automatic do_cmd(input logic [1:0] m, input logic [2:0] a, input logic dv);
    @(negedge clk);
    en = 1'b1; mode = m; addr = a; d = dv;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    tests_run++; if (q8 !== 8'h00) begin tests_failed++; $display("FAIL reset_q8: got %h want %h", q8, 8'h00); end
    tests_run++; if (err8 !== 1'b0) begin tests_failed++; $display("FAIL reset_err8: got %b want 0", err8); end
    tests_run++; if (q6 !== 6'h00) begin tests_failed++; $display("FAIL reset_q6: got %h want %h", q6, 6'h00); end
    idle(2);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latch();
    do_cmd(M_LATCH, 3'd3, 1'b1);
    tests_run++; if (q8 !== 8'h08) begin tests_failed++; $display("FAIL latch_first: got %h want %h", q8, 8'h08); end
    do_cmd(M_LATCH, 3'd6, 1'b1);
    tests_run++; if (q8 !== 8'h48) begin tests_failed++; $display("FAIL latch_two: got %h want %h", q8, 8'h48); end
    do_cmd(M_LATCH, 3'd3, 1'b0);
    tests_run++; if (q8 !== 8'h40) begin tests_failed++; $display("FAIL latch_clear_bit: got %h want %h", q8, 8'h40); end
  endtask

  task automatic test_demux_toggle();
    for (int i = 0; i < 8; i++) begin
      do_cmd(M_LATCH, 3'(i), 1'b1);
    end
    tests_run++; if (q8 !== 8'hFF) begin tests_failed++; $display("FAIL fill_all: got %h want %h", q8, 8'hFF); end
    do_cmd(M_DEMUX, 3'd2, 1'b1);
    tests_run++; if (q8 !== 8'h04) begin tests_failed++; $display("FAIL demux: got %h want %h", q8, 8'h04); end
    do_cmd(M_TOGGLE, 3'd2, 1'b1);
    tests_run++; if (q8 !== 8'h00) begin tests_failed++; $display("FAIL toggle_off: got %h want %h", q8, 8'h00); end
    do_cmd(M_TOGGLE, 3'd2, 1'b0);
    tests_run++; if (q8 !== 8'h04) begin tests_failed++; $display("FAIL toggle_on: got %h want %h", q8, 8'h04); end
    // clr together with a LATCH command: clr must win
    @(negedge clk);
    clr = 1'b1; en = 1'b1; mode = M_LATCH; addr = 3'd3; d = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; en = 1'b0;
    tests_run++; if (q8 !== 8'h00) begin tests_failed++; $display("FAIL clr_over_en: got %h want %h", q8, 8'h00); end
  endtask

  task automatic test_out_of_range();
    do_clr();
    do_cmd(M_LATCH, 3'd1, 1'b1);
    do_cmd(M_LATCH, 3'd7, 1'b1);
    tests_run++; if (q6 !== 6'h02) begin tests_failed++; $display("FAIL oor_q_held: got %h want %h", q6, 6'h02); end
    tests_run++; if (err6 !== 1'b1) begin tests_failed++; $display("FAIL oor_err_set: got %b want 1", err6); end
    tests_run++; if (err8 !== 1'b0) begin tests_failed++; $display("FAIL inrange_no_err: got %b want 0", err8); end
    tests_run++; if (q8 !== 8'h82) begin tests_failed++; $display("FAIL inrange_write: got %h want %h", q8, 8'h82); end
    idle(1);
    tests_run++; if (err6 !== 1'b0) begin tests_failed++; $display("FAIL oor_err_one_cycle: got %b want 0", err6); end
    tests_run++; if (q6 !== 6'h02) begin tests_failed++; $display("FAIL oor_q_after: got %h want %h", q6, 6'h02); end
  endtask

`ifdef ADDR_LATCH_PULSE_EN
  task automatic test_pulse();
    do_clr();
    do_cmd(M_PULSE, 3'd5, 1'b1);                 // edge 0
    tests_run++; if (q8 !== 8'h20) begin tests_failed++; $display("FAIL pulse_rise: got %h want %h", q8, 8'h20); end
    idle(3);                                      // edges 1..3
    tests_run++; if (q8 !== 8'h20) begin tests_failed++; $display("FAIL pulse_hold: got %h want %h", q8, 8'h20); end
    idle(1);                                      // edge 4
    tests_run++; if (q8 !== 8'h00) begin tests_failed++; $display("FAIL pulse_fall: got %h want %h", q8, 8'h00); end

    do_cmd(M_PULSE, 3'd5, 1'b1);                 // edge 0
    idle(1);                                      // edge 1
    do_cmd(M_PULSE, 3'd5, 1'b1);                 // edge 2 retrigger
    idle(3);                                      // edges 3..5
    tests_run++; if (q8 !== 8'h20) begin tests_failed++; $display("FAIL retrig_hold: got %h want %h", q8, 8'h20); end
    idle(1);                                      // edge 6
    tests_run++; if (q8 !== 8'h00) begin tests_failed++; $display("FAIL retrig_fall: got %h want %h", q8, 8'h00); end

    do_cmd(M_PULSE, 3'd5, 1'b1);
    do_cmd(M_LATCH, 3'd5, 1'b1);
    idle(8);
    tests_run++; if (q8 !== 8'h20) begin tests_failed++; $display("FAIL latch_cancels_timer: got %h want %h", q8, 8'h20); end

    do_cmd(M_PULSE, 3'd4, 1'b1);
    do_cmd(M_PULSE, 3'd4, 1'b0);
    tests_run++; if (q8 !== 8'h20) begin tests_failed++; $display("FAIL pulse_d0_clears: got %h want %h", q8, 8'h20); end
  endtask

  task automatic test_simultaneous();
    do_clr();
    do_cmd(M_PULSE, 3'd1, 1'b1);                 // edge 0
    idle(3);                                      // edges 1..3, timer now 1
    do_cmd(M_PULSE, 3'd1, 1'b1);                 // edge 4: expiry and reload
    tests_run++; if (q8 !== 8'h02) begin tests_failed++; $display("FAIL expire_vs_cmd: got %h want %h", q8, 8'h02); end
    idle(3);                                      // edges 5..7
    tests_run++; if (q8 !== 8'h02) begin tests_failed++; $display("FAIL reload_full: got %h want %h", q8, 8'h02); end
    idle(1);                                      // edge 8
    tests_run++; if (q8 !== 8'h00) begin tests_failed++; $display("FAIL reload_fall: got %h want %h", q8, 8'h00); end

    do_cmd(M_PULSE, 3'd0, 1'b1);                 // edge 0
    idle(3);
    do_cmd(M_LATCH, 3'd7, 1'b1);                 // edge 4: bit 0 expires too
    tests_run++; if (q8 !== 8'h80) begin tests_failed++; $display("FAIL expire_plus_latch: got %h want %h", q8, 8'h80); end
  endtask
`else
  task automatic test_macro_off();
    do_clr();
    do_cmd(M_PULSE, 3'd0, 1'b1);
    tests_run++; if (q8 !== 8'h01) begin tests_failed++; $display("FAIL pulse_as_latch_set: got %h want %h", q8, 8'h01); end
    idle(8);
    tests_run++; if (q8 !== 8'h01) begin tests_failed++; $display("FAIL pulse_as_latch_hold: got %h want %h", q8, 8'h01); end
  endtask
`endif

  task automatic test_reset_mid_pulse();
    do_clr();
    do_cmd(M_PULSE, 3'd2, 1'b1);
    tests_run++; if (q6 !== 6'h04) begin tests_failed++; $display("FAIL mid_pulse_set: got %h want %h", q6, 6'h04); end
    #2 rst = 1'b1;                                // between clock edges
    #1;
    tests_run++; if (q6 !== 6'h00) begin tests_failed++; $display("FAIL async_reset_q: got %h want %h", q6, 6'h00); end
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    tests_run++; if (q6 !== 6'h00) begin tests_failed++; $display("FAIL after_release: got %h want %h", q6, 6'h00); end
    do_cmd(M_LATCH, 3'd3, 1'b1);
    idle(6);
    tests_run++; if (q6 !== 6'h08) begin tests_failed++; $display("FAIL post_reset_latch: got %h want %h", q6, 6'h08); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latch();
    test_demux_toggle();
    test_out_of_range();
`ifdef ADDR_LATCH_PULSE_EN
    test_pulse();
    test_simultaneous();
`else
    test_macro_off();
`endif
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/addr_latch_bank.md
# addr_latch_bank

Parametrised, clocked addressable latch bank that drives N individually addressable control bits from a serial address/data write port. It is the generalised successor to the fixed 8-bit addressable latch used for board-level control decode. It adds demux, toggle and self-clearing pulse modes, a synchronous clear and out-of-range address detection. It sits between the CPU write decode and the discrete control lines it drives (lamps, coin counters, sound triggers, watchdog strobes).

## Interface
- N, default 8: number of output bits; legal range 2..64.
- PULSE_LEN, default 4: cycles a pulse-mode bit stays high; must be >= 1.
- AW, derived, not overridable: max(1, $clog2(N)).
- TW, derived, not overridable: $clog2(PULSE_LEN+1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  write strobe; a command executes on each edge where en=1.
- clr  input  1  synchronous clear of all bits and timers.
- mode  input  2  command: 00 LATCH, 01 DEMUX, 10 PULSE, 11 TOGGLE.
- addr  input  AW  bit select.
- d  input  1  write data.
- q  output  N  latched control bits.
- err  output  1  one-cycle flag for an out-of-range write.

## Operation
- Reset (async): q=0, err=0, all timers=0.
- Priority per edge: rst > clr > en command > timer expiry.
- clr=1: q=0, timers=0, err=0; en is ignored that cycle.
- LATCH: q[addr]<=d; cancels the timer of that bit.
- DEMUX: q<=0 except q[addr]<=d; cancels all timers.
- PULSE: q[addr]<=d.
  - If d=1, timer[addr]<=PULSE_LEN; a re-trigger reloads the timer and never shortens it.
  - If d=0, the bit clears and its timer cancels.
- TOGGLE: q[addr]<=~q[addr]; d is ignored; cancels the timer of that bit.
- Timer: each nonzero timer decrements every edge not overridden by a command to that bit.
  - When a timer equal to 1 decrements, q bit <=0 and the timer <=0.
- Out-of-range address (addr >= N, only possible when N is not a power of 2): no state change; err=1 for the next cycle.
- err: registered; it is 0 on every edge without an out-of-range write.
- Untouched bits always hold their value, apart from timer expiry and clr.

## Timing
- Write latency: a command sampled at edge k is visible on q after edge k; q is registered with no combinational path from the inputs.
- Pulse width: a PULSE d=1 write at edge k makes q high after edge k and low after edge k+PULSE_LEN, i.e. exactly PULSE_LEN cycles.
- Command to a bit in the same cycle its timer expires: the command result wins.
- Command to bit A while bit B's timer expires: both take effect in the same edge.
- Reset asserted mid-pulse: q and timers clear immediately; no expiry occurs after release.
- Back-to-back writes every cycle are supported with no stall and no busy signal.

## Configuration
- ADDR_LATCH_PULSE_EN defined: per-bit TW-wide timers exist and behave as above.
- ADDR_LATCH_PULSE_EN undefined:
  - No timers are synthesised.
  - PULSE mode behaves exactly as LATCH.
  - PULSE_LEN is ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset/LATCH (N=8): assert rst → q=00, err=0. LATCH addr=3 d=1, then addr=6 d=1 → q=0x48. LATCH addr=3 d=0 → q=0x40.
- DEMUX/TOGGLE: from q=0xFF, DEMUX addr=2 d=1 → q=0x04. TOGGLE addr=2 twice → q=0x00, then 0x04. clr with en=1 → q=0x00.
- Pulse and retrigger (PULSE_LEN=4): PULSE addr=5 d=1 at edge 0 → q[5]=1 for edges 0..3, 0 after edge 4. Retrigger at edge 2 → low after edge 6. LATCH addr=5 d=1 at edge 1 → stays high indefinitely.
- Simultaneous events: bit 1's timer expires on the same edge as PULSE addr=1 d=1 → q[1] stays 1 with a full reload. Bit 0 expiry alongside LATCH addr=7 → both updates apply.
- Out of range / reset mid-pulse (N=6): LATCH addr=7 → q unchanged, err=1 for exactly one cycle. Async rst mid-pulse → q=0 without waiting for clk, and no late clear after release.
- Macro off: PULSE addr=0 d=1 → q[0] remains 1 after 2×PULSE_LEN cycles.
